// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the odd-parity generator/checker pair.
// Contents:
//   state_t        - frame FSM states of the serial checker (S_DATA, S_PAR)
//   DEFAULT_DATA_W - default number of data bits per frame
//   PARITY_MAX_W   - widest vector parity_f accepts (narrower data is zero-extended)
//   parity_f       - XOR reduction; 1 when the data holds an odd count of ones
package arith_pkg;

    typedef enum logic {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 4;
    localparam int PARITY_MAX_W   = 32;

    // Zero-extension leaves the XOR unchanged, so one fixed-width function
    // serves every frame width up to PARITY_MAX_W.
    function automatic logic parity_f(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_deser.sv
// Serial-to-parallel shift register with bit counter for the data part of a frame.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   accept in   a data bit is taken this cycle
//   bit_in in   value of that data bit
//   abort  in   drop the partial frame (counter and shift register to 0)
//   shift  out  collected data, bit 0 = first bit received
//   done   out  the bit accepted this cycle is the last data bit of the frame
module serial_deser #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              bit_in,
    input  logic              abort,
    output logic [DATA_W-1:0] shift,
    output logic              done
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [CW-1:0] bit_cnt;

    assign done = accept & (bit_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (abort) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shift[bit_cnt] <= bit_in;
            // Counter wraps to 0 after the last data bit; the parity bit is
            // handled by the top-level FSM, not counted here.
            bit_cnt <= done ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/odd_parity_serial_checker.sv
// Receive-side odd-parity checker: collects DATA_W serial data bits and one
// parity bit, recomputes the XOR of the data and flags a mismatch. Completed
// frames sit in a valid/ready output register; a saturating counter tallies
// frames with a parity error.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   in_valid    in   serial bit offered this cycle
//   in_bit      in   serial bit value
//   in_ready    out  checker takes in_bit this cycle
//   in_abort    in   discard the partially received frame
//   out_valid   out  completed frame held in the output register
//   out_ready   in   consumer takes the frame
//   out_data    out  received data, bit 0 = first bit received
//   out_par_err out  XOR(out_data) differs from the received parity bit
//   err_cnt     out  saturating count of frames with a parity error
//   cnt_clr     in   synchronous clear of err_cnt (wins over an increment)
// Handshake: a transfer happens on an edge where valid and ready are both 1;
// a producer holds its offer until then, and ready may depend on the other
// side's ready combinationally (in_ready follows out_ready on the parity bit).
module odd_parity_serial_checker
    import arith_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    input  logic              in_abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              data_acc;
    logic              par_acc;
    logic [DATA_W-1:0] shift;
    logic              deser_done;
    logic              frame_err;

    // Only the parity bit can stall, and only while the previous frame is
    // still unclaimed; data bits never wait on the consumer.
    assign in_ready = ~((state_q == S_PAR) & out_valid & ~out_ready);

    // An abort cycle discards whatever bit is offered alongside it.
    assign accept   = in_valid & in_ready & ~in_abort;
    assign data_acc = accept & (state_q == S_DATA);
    assign par_acc  = accept & (state_q == S_PAR);

    assign frame_err = parity_f(PARITY_MAX_W'(shift)) ^ in_bit;

    serial_deser #(
        .DATA_W (DATA_W)
    ) u_deser (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (data_acc),
        .bit_in (in_bit),
        .abort  (in_abort),
        .shift  (shift),
        .done   (deser_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_abort) begin
            state_d = S_DATA;
        end else if (deser_done) begin
            state_d = S_PAR;
        end else if (par_acc) begin
            state_d = S_DATA;
        end
    end

    // Output register: a completing frame loads even while the old one is
    // being taken, giving back-to-back frames without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_par_err <= 1'b0;
        end else if (par_acc) begin
            out_valid   <= 1'b1;
            out_data    <= shift;
            out_par_err <= frame_err;
        end else if (out_valid & out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (par_acc & frame_err & (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_odd_parity_serial_checker.sv
module tb_odd_parity_serial_checker;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_bit;
    logic              in_ready;
    logic              in_abort;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_par_err;
    logic [CNT_W-1:0]  err_cnt;
    logic              cnt_clr;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    odd_parity_serial_checker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .in_abort    (in_abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_par_err (out_par_err),
        .err_cnt     (err_cnt),
        .cnt_clr     (cnt_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p);
        for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
        send_bit(p);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_abort  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        tick(); tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_par_err", out_par_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // All-zero frame, good parity
        send_frame(4'b0000, 1'b0);
        check("f0_valid", out_valid, 1);
        check("f0_data", out_data, 4'h0);
        check("f0_err", out_par_err, 0);
        check("f0_cnt", err_cnt, 0);
        tick();
        check("f0_valid_one_cycle", out_valid, 0);

        // 1011 has three ones: p=0 is wrong, p=1 is right
        send_frame(4'b1011, 1'b0);
        check("f1_data", out_data, 4'hB);
        check("f1_err", out_par_err, 1);
        check("f1_cnt", err_cnt, 1);
        send_frame(4'b1011, 1'b1);
        check("f2_err", out_par_err, 0);
        check("f2_cnt", err_cnt, 1);
        tick();

        // Backpressure: hold 0001 while the next frame 1100 arrives
        out_ready = 1'b0;
        send_frame(4'b0001, 1'b1);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 4'h1);
        check("bp_err", out_par_err, 0);
        for (int i = 0; i < DATA_W; i++) begin
            in_valid = 1'b1;
            in_bit   = (i >= 2);
            #1;
            check("bp_data_bit_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            check("bp_data_held", out_data, 4'h1);
        end
        in_valid = 1'b1;
        in_bit   = 1'b0;
        #1;
        check("bp_par_stall", in_ready, 0);
        tick();
        check("bp_hold_data", out_data, 4'h1);
        check("bp_hold_valid", out_valid, 1);
        check("bp_still_stall", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("b2b_valid", out_valid, 1);
        check("b2b_data", out_data, 4'hC);
        check("b2b_err", out_par_err, 0);
        tick();
        check("b2b_drain", out_valid, 0);

        // Abort after two data bits; the bit offered with the abort is dropped
        send_bit(1'b1);
        send_bit(1'b1);
        in_abort = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        in_abort = 1'b0;
        in_valid = 1'b0;
        send_frame(4'b0110, 1'b0);
        check("abort_data", out_data, 4'h6);
        check("abort_err", out_par_err, 0);
        check("abort_cnt", err_cnt, 1);

        // Saturation of a 2-bit counter
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt", err_cnt, 0);
        for (int i = 1; i <= 5; i++) begin
            send_frame(4'b0001, 1'b0);
            check("sat_err", out_par_err, 1);
            check("sat_cnt", err_cnt, (i > 3) ? 3 : i);
        end
        for (int i = 0; i < DATA_W; i++) send_bit(i == 0);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        cnt_clr  = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        check("clr_wins_cnt", err_cnt, 0);
        check("clr_wins_err", out_par_err, 1);
        tick();

        // Reset mid-frame with a full output register
        out_ready = 1'b0;
        send_frame(4'b0101, 1'b1);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_cnt", err_cnt, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_err", out_par_err, 0);
        check("mid_rst_cnt", err_cnt, 0);
        check("mid_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        send_frame(4'b1111, 1'b0);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 4'hF);
        check("post_rst_err", out_par_err, 0);
        check("post_rst_cnt", err_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/odd_parity_serial_checker.md
Name: odd_parity_serial_checker

Overview:
Receive-side counterpart of the 4-input odd-signal (XOR parity) generator in the ARITHMETIC set. Deserialises frames of DATA_W data bits followed by one parity bit, recomputes the XOR of the data, and compares it with the received parity bit. It presents each frame on a valid/ready output register with an error flag, and keeps a saturating error counter. It sits between a serial link carrying generator output and downstream consumer logic.

Parameters:
DATA_W, 4, data bits per frame (in0..in3 order, first received = bit 0)
CNT_W, 8, width of saturating parity-error counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  serial bit offered this cycle
in_bit  input  1  serial bit value
in_ready  output  1  checker accepts in_bit this cycle
in_abort  input  1  discard partially received frame
out_valid  output  1  completed frame held in output register
out_ready  input  1  consumer takes frame
out_data  output  DATA_W  received data, bit 0 = first bit received
out_par_err  output  1  1 when XOR(out_data) != received parity bit
err_cnt  output  CNT_W  count of frames with parity error, saturating
cnt_clr  input  1  synchronous clear of err_cnt

Behaviour:
- Reset (rst_n=0 at edge): state=S_DATA, bit_cnt=0, shift reg=0, out_valid=0, out_data=0, out_par_err=0, err_cnt=0. in_ready reads 1 out of reset. A reset mid-frame or mid-handshake discards everything.
- Bit accepted = in_valid & in_ready.
- FSM S_DATA: each accepted bit goes to shift[bit_cnt], bit_cnt++. On the accept with bit_cnt==DATA_W-1, go to S_PAR.
- FSM S_PAR: the accepted bit is the parity bit p. In the same edge, load out_data=shift, out_par_err=(^shift)^p, out_valid=1. Return to S_DATA with bit_cnt=0.
- Latency: out_valid rises on the edge that accepts the parity bit, visible the cycle after the parity bit is presented.
- in_ready = ~(state==S_PAR & out_valid & ~out_ready). The checker stalls only on the parity bit while the output register is full. Data bits are always accepted.
- out_valid/out_data/out_par_err hold stable while out_valid & ~out_ready.
- out_valid clears on out_valid & out_ready, unless a new frame completes on the same edge. In that case the new frame loads and out_valid stays 1 (back-to-back, no bubble).
- err_cnt increments by 1 on each frame completion with a parity mismatch. It saturates at 2^CNT_W-1 with no wrap.
- cnt_clr wins over a simultaneous increment: err_cnt=0.
- in_abort: state=S_DATA, bit_cnt=0, shift=0. Any bit offered that cycle is discarded. The output register and err_cnt are unaffected.
- in_valid=0 cycles inside a frame are idle. There is no timeout.
- Parity rule is identical to the generator: expected p = XOR of the data bits (1 for an odd count of ones).

Decomposition:
- Shared package arith_pkg: state enum (S_DATA, S_PAR), default DATA_W=4, and the function parity_f(data) returning the XOR reduction. The generator and this checker share parity_f.
- One natural sub-module, serial_deser: shift register plus bit counter with accept/abort/done. The FSM, output register and counter stay in the top.

Test Plan:
- Reset then in_bit 0,0,0,0,p=0, out_ready=1 -> out_valid=1 for one cycle, out_data=4'b0000, out_par_err=0, err_cnt=0.
- Bits 1,1,0,1 (data 4'b1011), p=0 -> out_par_err=1, err_cnt=1. Same data with p=1 -> out_par_err=0, err_cnt stays 1.
- out_ready=0, frame 4'b0001 p=1, then next frame's 4 data bits and parity offered:
  - in_ready drops only on the parity bit; out_data stays 4'b0001.
  - Raise out_ready -> same edge accepts parity, new frame loads, out_valid stays 1.
- in_abort after 2 data bits, then full frame 4'b0110 p=0 -> out_data=4'b0110, out_par_err=0. The first 2 bits are lost.
- CNT_W=2, 5 consecutive bad-parity frames -> err_cnt=3 (saturated). Assert cnt_clr on the same cycle as a 6th bad frame -> err_cnt=0.
- rst_n=0 after 3 data bits with out_valid=1 -> all outputs reset values. Next full frame 4'b1111 p=0 decodes cleanly.
